fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch initiator for the pipelined rv32i core: owns the fetch PC, issues word reads on the instruction-side `mem_itf` port (addr/rmask/rdata/resp), and buffers returned instructions with their PCs in a small FIFO toward decode. It is the requesting end of the same instruction memory protocol the memory models and random testbench answer. It supports at most one outstanding read and handles redirects by flushing the FIFO and discarding stale responses.

## Interface
- `RESET_PC`, 32'h1eceb000, first fetch address after reset
- `QDEPTH`, 4, instruction FIFO entries (power of two, ≥2)

- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `redirect`  in  1  branch/jump redirect strobe
- `redirect_pc`  in  32  new fetch address (4-byte aligned)
- `imem_addr`  out  32  read address
- `imem_rmask`  out  4  4'b1111 on the issue cycle, else 0
- `imem_rdata`  in  32  read data, valid when `imem_resp`
- `imem_resp`  in  1  one-cycle response pulse
- `out_valid`  out  1  FIFO head valid
- `out_inst`  out  32  head instruction
- `out_pc`  out  32  head PC
- `out_ready`  in  1  decode accepts head

## Operation
- States: IDLE (nothing outstanding), WAIT (read outstanding, result kept), DISCARD (read outstanding, result dropped).
- Registers: `fetch_pc` (next address), `inflight_pc`, FIFO (inst, pc) with `count` 0..QDEPTH.
- Issue condition (combinational): !rst && (state==IDLE || imem_resp) && count_next < QDEPTH, where count_next = count + push − pop for this cycle.
- On issue: `imem_rmask`=4'b1111, `imem_addr`=issue address; `inflight_pc`<=issue address; `fetch_pc`<=issue address+4; state<=WAIT. Issue address = `redirect_pc` if `redirect`, else `fetch_pc`.
- No issue: `imem_rmask`=0, `imem_addr`=`fetch_pc` (don't-care).
- Response in WAIT without redirect: push {imem_rdata, inflight_pc}. Response in DISCARD: dropped. If no issue, state<=IDLE.
- Response without outstanding request (IDLE): ignored.
- Pop: out_valid && out_ready && !redirect.
- Redirect (priority over push/pop): FIFO flushed (count<=0); `fetch_pc`<=redirect_pc (+4 if issued). Same-cycle response is dropped. If a read is outstanding and no resp this cycle: state<=DISCARD, no issue; redirect target issued on the cycle the stale resp arrives.
- Redirect while in DISCARD: update `fetch_pc`, remain DISCARD.
- Simultaneous push and pop at count==QDEPTH: legal, count unchanged.
- Arithmetic: 32-bit PC wraps modulo 2^32; FIFO pointers wrap modulo QDEPTH.

## Timing
- Reset values: state IDLE, `fetch_pc`=RESET_PC, count 0, `out_valid`=0, `imem_rmask`=0, `out_inst`/`out_pc`=0.
- First request: first cycle with rst low, addr=RESET_PC.
- Issue at T, resp earliest T+1; pushed entry visible on `out_valid` at resp cycle+1.
- Next issue may coincide with resp cycle: steady-state throughput 1 instr/cycle with 1-cycle memory latency.
- `imem_rmask` high exactly one cycle per request; never asserted while a read is outstanding and no resp.
- Reset mid-operation: all state reset next edge; responses arriving after reset deasserts with no new issue are ignored.
- `out_valid`/`out_inst`/`out_pc` driven from FIFO registers, no combinational path from `imem_rdata`.

## Test plan
- Reset 3 cycles, memory resp 1 cycle after each request -> rmask=4'b1111 at addr 1eceb000, 1eceb004, 1eceb008 on consecutive cycles; out_pc follows same sequence, out_valid from cycle 3.
- out_ready=0, resp always 1 cycle -> exactly 4 requests, count=4, rmask stays 0; raise out_ready -> one pop, one new request at 1eceb010.
- Request 1eceb000 outstanding, redirect to 1eceb100 before resp, resp after 3 cycles with rdata 0xdeadbeef -> 0xdeadbeef never on out_inst; next request addr 1eceb100 on the resp cycle.
- Redirect to 1eceb200 in the same cycle as a resp -> resp dropped, FIFO empty next cycle, request at 1eceb200 issued that cycle.
- Random resp delays (1–5 cycles) and random out_ready, 10k cycles -> out_pc strictly +4 sequence except after redirects, no lost/duplicated instructions versus scoreboard.
- Assert rst with 2 FIFO entries and a read outstanding -> next cycle out_valid=0, rmask=0; after release first request at 1eceb000, stale resp ignored.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-side bus bundle for the fetch unit: memory read port,
// redirect request from the back end, and the decoded-instruction stream.
interface fetch_unit_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;

    modport master (
        input  redirect, redirect_pc, imem_rdata, imem_resp, out_ready,
        output imem_addr, imem_rmask, out_valid, out_inst, out_pc
    );

    modport slave (
        output redirect, redirect_pc, imem_rdata, imem_resp, out_ready,
        input  imem_addr, imem_rmask, out_valid, out_inst, out_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, keeps at most one word read
// outstanding on the instruction port, and queues returned instructions with
// their PCs toward decode. Redirects flush the queue and any response that
// belongs to the old path is thrown away.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000,
    parameter int          QDEPTH   = 4
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW:0] DEPTH_L = (PW + 1)'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;

    logic [31:0]   inst_q [QDEPTH];
    logic [31:0]   pc_q   [QDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    logic          push;
    logic          pop;
    logic [PW:0]   count_next;
    logic          issue;
    logic [31:0]   issue_addr;

    // Decide this cycle's queue movement and whether a new read can go out;
    // a redirect empties the queue, so it always leaves room for the target.
    always_comb begin
        push       = bus.imem_resp && (state == WAIT) && !bus.redirect;
        pop        = (count != '0) && bus.out_ready && !bus.redirect;
        count_next = count;
        if (bus.redirect) begin
            count_next = '0;
        end else begin
            count_next = count + (PW + 1)'(push) - (PW + 1)'(pop);
        end
        issue_addr = bus.redirect ? bus.redirect_pc : fetch_pc;
        issue      = !rst && ((state == IDLE) || bus.imem_resp) && (count_next < DEPTH_L);
    end

    assign bus.imem_rmask = issue ? 4'b1111 : 4'b0000;
    assign bus.imem_addr  = issue ? issue_addr : fetch_pc;
    assign bus.out_valid  = (count != '0);
    assign bus.out_inst   = inst_q[rd_ptr];
    assign bus.out_pc     = pc_q[rd_ptr];

    // Request tracking: next fetch address and whether the outstanding read is kept or dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
        end else if (issue) begin
            state       <= WAIT;
            inflight_pc <= issue_addr;
            fetch_pc    <= issue_addr + 32'd4;
        end else begin
            if (bus.redirect) begin
                fetch_pc <= bus.redirect_pc;
            end
            if (state != IDLE) begin
                if (bus.imem_resp) begin
                    state <= IDLE;
                end else if (bus.redirect) begin
                    state <= DISCARD;
                end
            end
        end
    end

    // Instruction queue: circular buffer of (instruction, pc), flushed on redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (bus.redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                inst_q[wr_ptr] <= bus.imem_rdata;
                pc_q[wr_ptr]   <= inflight_pc;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_next;
        end
    end
endmodule
